// File: rtl/poly_pkg.sv
// Shared widths, watchdog default and FSM state encoding for the poly_solver
// front end (arbiter and solver).
package poly_pkg;

  localparam int X_W         = 8;
  localparam int COEF_W      = 16;
  localparam int Y_W         = 16;
  localparam int TIMEOUT_DEF = 64;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_ISSUE      = 2'd1;
  localparam logic [1:0] S_WAIT_VALID = 2'd2;
  localparam logic [1:0] S_WAIT_READY = 2'd3;

endpackage

// File: rtl/poly_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request bit at or after ptr,
// wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);

  localparam int unsigned NU = N_REQ;

  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] sel;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int unsigned i = 0; i < NU; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NU) idx = idx - NU;
      sel = ID_W'(idx);
      if (!any && req[sel]) begin
        any        = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/poly_arbiter.sv
// Round-robin arbiter sharing one poly_solver between N_REQ requesters; returns
// id-tagged results and aborts hung solver operations with a watchdog.
module poly_arbiter
  import poly_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ID_W    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*X_W-1:0]      req_x,
  input  logic [N_REQ*COEF_W-1:0]   req_a,
  input  logic [N_REQ*COEF_W-1:0]   req_b,
  input  logic [N_REQ*COEF_W-1:0]   req_c,
  output logic [N_REQ-1:0]          req_ack,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [Y_W-1:0]            resp_y,
  output logic                      resp_err,
  output logic                      busy,
  output logic                      sv_enable,
  output logic [X_W-1:0]            sv_x,
  output logic [COEF_W-1:0]         sv_a,
  output logic [COEF_W-1:0]         sv_b,
  output logic [COEF_W-1:0]         sv_c,
  input  logic                      sv_ready,
  input  logic                      sv_valid,
  input  logic [Y_W-1:0]            sv_y
);

  localparam int WD_W = $clog2(TIMEOUT);

  logic [1:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_q;
  logic [WD_W-1:0]  wdog;
  logic [WD_W-1:0]  wdog_inc;
  logic             sv_valid_q;
  logic             vedge;
  logic             take;

  logic [N_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (pick_onehot),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign take      = (state == S_IDLE) && sv_ready && pick_any;
  assign vedge     = sv_valid && !sv_valid_q;
  assign wdog_inc  = wdog + 1'b1;
  assign busy      = (state != S_IDLE);
  assign sv_enable = (state == S_ISSUE);

  // Ack is combinational so it coincides with the operand capture edge; it is
  // masked while reset is held so all outputs read zero during reset.
  always_comb begin
    req_ack = '0;
    if (take && reset) req_ack = pick_onehot;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant_q    <= '0;
      wdog       <= '0;
      sv_valid_q <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_y     <= '0;
      resp_err   <= 1'b0;
      sv_x       <= '0;
      sv_a       <= '0;
      sv_b       <= '0;
      sv_c       <= '0;
    end else begin
      sv_valid_q <= sv_valid;
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take) begin
            sv_x    <= req_x[pick_idx*X_W +: X_W];
            sv_a    <= req_a[pick_idx*COEF_W +: COEF_W];
            sv_b    <= req_b[pick_idx*COEF_W +: COEF_W];
            sv_c    <= req_c[pick_idx*COEF_W +: COEF_W];
            grant_q <= pick_idx;
            rr_ptr  <= (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdog  <= '0;
          state <= S_WAIT_VALID;
        end
        S_WAIT_VALID: begin
          if (vedge) begin
            resp_valid <= 1'b1;
            resp_y     <= sv_y;
            resp_id    <= grant_q;
            resp_err   <= 1'b0;
            state      <= S_WAIT_READY;
          end else begin
            // Abort is decided one cycle early so resp_valid lands TIMEOUT
            // cycles after sv_enable.
            wdog <= wdog_inc;
            if (wdog_inc == WD_W'(TIMEOUT - 1)) begin
              resp_valid <= 1'b1;
              resp_y     <= '0;
              resp_id    <= grant_q;
              resp_err   <= 1'b1;
              state      <= S_WAIT_READY;
            end
          end
        end
        S_WAIT_READY: begin
          if (sv_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_arbiter.sv
// Directed bench for poly_arbiter with a behavioural 5-cycle solver that can
// also hang or hold a stale valid.
module tb_poly_arbiter;

  localparam int N   = 4;
  localparam int TO  = 64;
  localparam int IDW = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*8-1:0]  req_x = '0;
  logic [N*16-1:0] req_a = '0, req_b = '0, req_c = '0;
  logic [N-1:0]    req_ack;
  logic            resp_valid, resp_err, busy, sv_enable;
  logic [IDW-1:0]  resp_id;
  logic [15:0]     resp_y;
  logic [7:0]      sv_x;
  logic [15:0]     sv_a, sv_b, sv_c;
  logic            sv_ready = 1'b1;
  logic            sv_valid = 1'b0;
  logic [15:0]     sv_y = '0;

  always #5 clock = ~clock;

  poly_arbiter #(.N_REQ(N), .TIMEOUT(TO), .ID_W(IDW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_x(req_x), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .req_ack(req_ack), .resp_valid(resp_valid), .resp_id(resp_id), .resp_y(resp_y),
    .resp_err(resp_err), .busy(busy), .sv_enable(sv_enable),
    .sv_x(sv_x), .sv_a(sv_a), .sv_b(sv_b), .sv_c(sv_c),
    .sv_ready(sv_ready), .sv_valid(sv_valid), .sv_y(sv_y)
  );

  // Solver model: mode 0 normal, 1 never completes, 2 keeps the old valid high
  // for three cycles after enable before producing the new result.
  int           mode = 0;
  logic         release_hang = 1'b0;
  int           mcnt = 0;
  logic         mrun = 1'b0;
  logic [7:0]   mx;
  logic [15:0]  ma, mb, mc;

  function automatic logic [15:0] poly(input logic signed [7:0] x,
                                       input logic signed [15:0] a, b, c);
    int r;
    r = int'(a) * int'(x) * int'(x) + int'(b) * int'(x) + int'(c);
    return r[15:0];
  endfunction

  always @(posedge clock) begin
    if (release_hang) begin
      mrun     <= 1'b0;
      sv_ready <= 1'b1;
    end else if (sv_enable) begin
      mx <= sv_x; ma <= sv_a; mb <= sv_b; mc <= sv_c;
      mcnt     <= 1;
      mrun     <= (mode != 1);
      sv_ready <= 1'b0;
      if (mode != 2) sv_valid <= 1'b0;
    end else if (mrun) begin
      mcnt <= mcnt + 1;
      if (mode == 2 && mcnt == 3) sv_valid <= 1'b0;
      if (mcnt == 5) begin
        sv_valid <= 1'b1;
        sv_y     <= poly(mx, ma, mb, mc);
        sv_ready <= 1'b1;
        mrun     <= 1'b0;
      end
    end
  end

  typedef struct { int id; logic [15:0] y; logic err; int cyc; } resp_t;
  typedef struct { int id; logic [7:0] x; logic [15:0] a, b, c, y; } vec_t;

  resp_t        q[$];
  resp_t        r;
  int           n_checks = 0, n_fail = 0;
  int           cyc = 0, n_ack = 0, n_en = 0, ack_cyc = 0, en_cyc = 0;
  logic [N-1:0] ack_s;
  logic         auto_drop = 1'b1;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [95:0] outs();
    return 96'({req_ack, resp_valid, resp_id, resp_y, resp_err, busy, sv_enable,
                sv_x, sv_a, sv_b, sv_c});
  endfunction

  // One clock: sample everything on the falling edge, then retire acked
  // requests just after the rising edge that captured them.
  task automatic step();
    @(negedge clock);
    ack_s = req_ack;
    if (resp_valid) q.push_back('{id: int'(resp_id), y: resp_y, err: resp_err, cyc: cyc});
    if (sv_enable) begin n_en++; en_cyc = cyc; end
    if (ack_s != '0) begin
      n_ack++;
      ack_cyc = cyc;
      check("ack_onehot", 96'($countones(ack_s)), 96'(1));
    end
    @(posedge clock);
    #1;
    cyc++;
    if (auto_drop) req_valid = req_valid & ~ack_s;
  endtask

  task automatic wait_resp(input int n, input int budget, input string nm);
    int k = 0;
    while (q.size() < n && k < budget) begin step(); k++; end
    check(nm, 96'(q.size() >= n), 96'(1));
  endtask

  task automatic load(input int id, input logic [7:0] x, input logic [15:0] a, b, c);
    req_x[id*8 +: 8]   = x;
    req_a[id*16 +: 16] = a;
    req_b[id*16 +: 16] = b;
    req_c[id*16 +: 16] = c;
  endtask

  task automatic expect_resp(input string nm, input int id, input logic [15:0] y, input logic err);
    if (q.size() > 0) begin
      r = q.pop_front();
      check({nm, "_id"}, 96'(r.id), 96'(id));
      check({nm, "_y"}, 96'(r.y), 96'(y));
      check({nm, "_err"}, 96'(r.err), 96'(err));
    end
  endtask

  vec_t vt[6];
  int   target;

  initial begin
    vt[0] = '{id: 0, x: 8'd2,   a: 16'd1,   b: 16'd2,      c: 16'd3,      y: 16'd11};
    vt[1] = '{id: 1, x: -8'sd3, a: 16'd2,   b: -16'sd1,    c: 16'd5,      y: 16'd26};
    vt[2] = '{id: 0, x: 8'd100, a: 16'd10,  b: 16'd0,      c: 16'd0,      y: 16'd34464};
    vt[3] = '{id: 2, x: 8'd10,  a: 16'd100, b: -16'sd7,    c: 16'd1000,   y: 16'd10930};
    vt[4] = '{id: 3, x: 8'h80,  a: 16'd1,   b: 16'd0,      c: 16'd0,      y: 16'd16384};
    vt[5] = '{id: 3, x: 8'd127, a: 16'd2,   b: 16'd0,      c: 16'd0,      y: 16'd32258};

    #2 reset = 1'b0;
    #3 check("reset_outputs", outs(), '0);
    step(); step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      load(vt[i].id, vt[i].x, vt[i].a, vt[i].b, vt[i].c);
      req_valid[vt[i].id] = 1'b1;
      wait_resp(1, 60, "vec_wait");
      expect_resp("vec", vt[i].id, vt[i].y, 1'b0);
      if (i == 0) begin
        check("first_ack_count", 96'(n_ack), 96'(1));
        check("first_enable_count", 96'(n_en), 96'(1));
        check("ack_to_enable", 96'(en_cyc - ack_cyc), 96'(1));
      end
      step(); step();
    end

    // rr_ptr is 0 here: 0 and 2 together, then 0 and 1 with the pointer at 3
    load(0, 8'd5, 16'd1, 16'd0, 16'd0);
    load(2, 8'd6, 16'd1, 16'd0, 16'd0);
    req_valid = 4'b0101;
    wait_resp(2, 120, "rr02_wait");
    expect_resp("rr02_first", 0, 16'd25, 1'b0);
    expect_resp("rr02_second", 2, 16'd36, 1'b0);
    load(0, 8'd1, 16'd0, 16'd0, 16'd9);
    load(1, 8'd2, 16'd0, 16'd0, 16'd4);
    req_valid = 4'b0011;
    wait_resp(2, 120, "rr01_wait");
    expect_resp("rr01_first", 0, 16'd9, 1'b0);
    expect_resp("rr01_second", 1, 16'd4, 1'b0);

    // A request withdrawn while the arbiter is busy is never granted
    load(0, 8'd1, 16'd0, 16'd0, 16'd7);
    req_valid[0] = 1'b1;
    target = n_ack + 1;
    for (int k = 0; k < 20 && n_ack < target; k++) step();
    req_valid[2] = 1'b1;
    step(); step();
    req_valid[2] = 1'b0;
    req_valid[1] = 1'b1;
    wait_resp(2, 120, "drop_wait");
    expect_resp("drop_first", 0, 16'd7, 1'b0);
    expect_resp("drop_second", 1, 16'd4, 1'b0);
    for (int k = 0; k < 30; k++) step();
    check("drop_no_extra", 96'(q.size()), 96'(0));

    // All four held continuously from rr_ptr=0
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    auto_drop = 1'b0;
    for (int i = 0; i < N; i++) load(i, 8'(i + 1), 16'd1, 16'd0, 16'd0);
    req_valid = '1;
    wait_resp(8, 200, "cont_wait");
    req_valid = '0;
    auto_drop = 1'b1;
    for (int i = 0; i < 8 && q.size() > 0; i++) begin
      r = q.pop_front();
      check("cont_id", 96'(r.id), 96'(i % N));
    end
    for (int k = 0; k < 20; k++) step();
    check("cont_no_extra", 96'(q.size()), 96'(0));

    // Hung solver: watchdog aborts exactly TO cycles after sv_enable
    mode = 1;
    load(1, 8'd3, 16'd1, 16'd1, 16'd1);
    req_valid[1] = 1'b1;
    wait_resp(1, TO + 30, "timeout_wait");
    if (q.size() > 0) check("timeout_latency", 96'(q[0].cyc - en_cyc), 96'(TO));
    expect_resp("timeout", 1, 16'd0, 1'b1);
    mode = 0;
    release_hang = 1'b1;
    step();
    release_hang = 1'b0;
    load(3, 8'd3, 16'd1, 16'd1, 16'd1);
    req_valid[3] = 1'b1;
    wait_resp(1, 60, "after_timeout_wait");
    expect_resp("after_timeout", 3, 16'd13, 1'b0);
    step(); step();

    // Valid still high from the previous job must not be taken as a result
    mode = 2;
    load(0, 8'd2, 16'd3, 16'd0, 16'd0);
    req_valid[0] = 1'b1;
    wait_resp(1, 60, "stale_wait");
    expect_resp("stale", 0, 16'd12, 1'b0);
    mode = 0;
    step(); step();

    // Reset in WAIT_VALID abandons the job silently
    load(2, 8'd4, 16'd3, 16'd2, 16'd1);
    req_valid[2] = 1'b1;
    target = n_en + 1;
    for (int k = 0; k < 20 && n_en < target; k++) step();
    #2 reset = 1'b0;
    #1 check("midop_reset_outputs", outs(), '0);
    for (int k = 0; k < 10; k++) step();
    reset = 1'b1;
    step(); step();
    check("midop_no_resp", 96'(q.size()), 96'(0));
    load(1, 8'd1, 16'd1, 16'd1, 16'd1);
    req_valid[1] = 1'b1;
    wait_resp(1, 60, "post_reset_wait");
    expect_resp("post_reset", 1, 16'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
